shift_operand_sequencer: RTL

- Sits between decode and execute, in front of the barrel shifter.
- Fetches the register operands for data-processing and single-data-transfer instructions through the two register-file read ports: Rn, Rm and, for register-shifted-register forms, Rs.
- Rs needs a third read, so for those forms the block inserts one extra read cycle and stalls decode.
- Presents the instruction, Rn value, shifter register input and shift-register input to execute under a valid/ready handshake.

---
 rtl/shift_operand_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/shift_operand_sequencer.sv
// shift_operand_sequencer
// Fetches register operands for data-processing / single-data-transfer
// instructions between decode and execute, in front of the barrel shifter.
// Rn and Rm are read through the two register-file ports on the accept cycle.
// Register-shifted-register (RSR) forms need Rs as well, so one extra read
// cycle (FETCH_RS) is inserted and decode is stalled for that cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   decode handshake, inst_in + pc_in
//   flush                 synchronous pipeline flush (highest priority)
//   rf_addr_a/b, rf_data_a/b  register-file read ports (combinational data)
//   out_valid / out_ready execute handshake
//   inst_out, rn_value, register_input, shift_register_input  held operands
//   rsr_stall_count       saturating count of inserted Rs read cycles
module shift_operand_sequencer #(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 4,
    parameter int PC_OFS     = 8,
    parameter int PC_OFS_RSR = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst_in,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic                flush,
    output logic [RADDR_W-1:0]  rf_addr_a,
    output logic [RADDR_W-1:0]  rf_addr_b,
    input  logic [DATA_W-1:0]   rf_data_a,
    input  logic [DATA_W-1:0]   rf_data_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         inst_out,
    output logic [DATA_W-1:0]   rn_value,
    output logic [DATA_W-1:0]   register_input,
    output logic [DATA_W-1:0]   shift_register_input,
    output logic [15:0]         rsr_stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_RS = 2'd1,
        ST_OUT      = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] PC_OFS_W     = DATA_W'(PC_OFS);
    localparam logic [DATA_W-1:0] PC_OFS_RSR_W = DATA_W'(PC_OFS_RSR);

    // Register-shifted-register data-processing form.
    function automatic logic is_rsr(input logic [31:0] inst);
        return (inst[27:26] == 2'b00) && !inst[25] && inst[4] && !inst[7];
    endfunction

    // R15 reads return the pipelined PC instead of register-file data;
    // RSR forms see the PC one stage further ahead.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] pc,
        input logic              rsr
    );
        logic [DATA_W-1:0] res;
        if (addr == 4'd15) begin
            res = rsr ? (pc + PC_OFS_RSR_W) : (pc + PC_OFS_W);
        end else begin
            res = rf;
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        inst_q, inst_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  rn_q, rn_d;
    logic [DATA_W-1:0]  rm_q, rm_d;
    logic [DATA_W-1:0]  rs_q, rs_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               in_rsr_s;

    // Handshake toward decode: ready in IDLE, or in OUT when execute drains.
    always_comb begin
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_OUT) && out_ready);
        end
        accept_s = in_valid && in_ready_s;
        in_rsr_s = is_rsr(inst_in);
    end

    // Register-file address drive: held Rs/Rm during the extra read, else decode fields.
    always_comb begin
        rf_addr_a = RADDR_W'(inst_in[19:16]);
        rf_addr_b = RADDR_W'(inst_in[3:0]);
        if (state_q == ST_FETCH_RS) begin
            rf_addr_a = RADDR_W'(inst_q[11:8]);
            rf_addr_b = RADDR_W'(inst_q[3:0]);
        end else begin
            rf_addr_a = RADDR_W'(inst_in[19:16]);
            rf_addr_b = RADDR_W'(inst_in[3:0]);
        end
    end

    // Next-state and operand capture; flush overrides all transitions.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        rn_d        = rn_q;
        rm_d        = rm_q;
        rs_d        = rs_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        // Every FETCH_RS cycle counts, even one killed by flush.
        if ((state_q == ST_FETCH_RS) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OUT: begin
                    if (accept_s) begin
                        inst_d      = inst_in;
                        pc_d        = pc_in;
                        rn_d        = pick_operand(inst_in[19:16], rf_data_a, pc_in, in_rsr_s);
                        rm_d        = pick_operand(inst_in[3:0], rf_data_b, pc_in, in_rsr_s);
                        rs_d        = '0;
                        state_d     = in_rsr_s ? ST_FETCH_RS : ST_OUT;
                        out_valid_d = !in_rsr_s;
                    end else if ((state_q == ST_OUT) && out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = state_q;
                        out_valid_d = out_valid_q;
                    end
                end
                ST_FETCH_RS: begin
                    rs_d        = pick_operand(inst_q[11:8], rf_data_a, pc_q, 1'b1);
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inst_q      <= 32'd0;
            pc_q        <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            rs_q        <= '0;
            cnt_q       <= 16'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            rn_q        <= rn_d;
            rm_q        <= rm_d;
            rs_q        <= rs_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready             = in_ready_s;
    assign out_valid            = out_valid_q;
    assign inst_out             = inst_q;
    assign rn_value             = rn_q;
    assign register_input       = rm_q;
    assign shift_register_input = rs_q;
    assign rsr_stall_count      = cnt_q;

endmodule
